// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: single-port byte RAM with a 2-bit command decoder.
// It sits behind an SPI slave. Each 10-bit received word carries a command
// in bits [9:8] and a payload in bits [7:0].
//   cmd 00: load write pointer    cmd 01: write data at write pointer
//   cmd 10: load read pointer     cmd 11: read data at read pointer
// Data commands that arrive before their pointer has been loaded are
// rejected and pulse err.
//
// Parameters:
//   MEM_DEPTH  number of bytes; must equal 2**ADDR_SIZE
//   ADDR_SIZE  pointer width (1..8); taken from din[ADDR_SIZE-1:0]
//   AUTO_INC   nonzero: post-increment the pointer after each data access
//
// Ports:
//   SCK       clock; all state changes on its rising edge
//   rst       asynchronous active-high reset
//   din       received word from the SPI slave
//   rx_valid  one-cycle strobe qualifying din
//   dout      read data to the SPI slave; holds until the next good read
//   tx_valid  one-cycle strobe, one cycle after a good read command
//   err       one-cycle strobe on a data command with no pointer loaded
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 0
) (
  input  logic       SCK,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       err
);

  typedef enum logic [1:0] {
    CmdWrAddr = 2'b00,
    CmdWrData = 2'b01,
    CmdRdAddr = 2'b10,
    CmdRdData = 2'b11
  } cmd_e;

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 wr_addr_valid;
  logic                 rd_addr_valid;

  cmd_e                 cmd;
  logic [ADDR_SIZE-1:0] payload_addr;
  logic                 mem_we;

  always_comb begin
    cmd          = cmd_e'(din[9:8]);
    payload_addr = din[ADDR_SIZE-1:0];
    mem_we       = rx_valid && (cmd == CmdWrData) && wr_addr_valid;
  end

  // Storage has no reset so it can map onto a plain RAM macro. A write
  // lands on the same edge that samples the command, so a read command in
  // the very next word already sees the new byte.
  always_ff @(posedge SCK) begin
    if (mem_we) begin
      mem[wr_addr] <= din[7:0];
    end
  end

  // Pointers wrap for free: MEM_DEPTH == 2**ADDR_SIZE, so ADDR_SIZE-bit
  // arithmetic rolls MEM_DEPTH-1 over to 0.
  always_ff @(posedge SCK or posedge rst) begin
    if (rst) begin
      dout          <= 8'h00;
      tx_valid      <= 1'b0;
      err           <= 1'b0;
      wr_addr       <= '0;
      rd_addr       <= '0;
      wr_addr_valid <= 1'b0;
      rd_addr_valid <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      err      <= 1'b0;
      if (rx_valid) begin
        unique case (cmd)
          CmdWrAddr: begin
            wr_addr       <= payload_addr;
            wr_addr_valid <= 1'b1;
          end
          CmdWrData: begin
            if (wr_addr_valid) begin
              if (AUTO_INC != 0) begin
                wr_addr <= wr_addr + 1'b1;
              end
            end else begin
              err <= 1'b1;
            end
          end
          CmdRdAddr: begin
            rd_addr       <= payload_addr;
            rd_addr_valid <= 1'b1;
          end
          CmdRdData: begin
            if (rd_addr_valid) begin
              dout     <= mem[rd_addr];
              tx_valid <= 1'b1;
              if (AUTO_INC != 0) begin
                rd_addr <= rd_addr + 1'b1;
              end
            end else begin
              err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl. It runs three instances side by side:
//   u0: 256 x 8, no auto-increment
//   u1: 256 x 8, auto-increment
//   u2: 16 x 8,  auto-increment; covers address masking and early wrap
// A byte-array reference model predicts tx_valid, err and dout after every
// clock edge.
module tb_spi_ram_ctrl;
  localparam int NI = 3;

  logic       SCK = 1'b0;
  logic       rst;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] d0, d1, d2;
  logic       t0, t1, t2;
  logic       e0, e1, e2;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) u0 (
    .SCK(SCK), .rst(rst), .din(din), .rx_valid(rx_valid),
    .dout(d0), .tx_valid(t0), .err(e0)
  );
  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) u1 (
    .SCK(SCK), .rst(rst), .din(din), .rx_valid(rx_valid),
    .dout(d1), .tx_valid(t1), .err(e1)
  );
  spi_ram_ctrl #(.MEM_DEPTH(16), .ADDR_SIZE(4), .AUTO_INC(1)) u2 (
    .SCK(SCK), .rst(rst), .din(din), .rx_valid(rx_valid),
    .dout(d2), .tx_valid(t2), .err(e2)
  );

  always #5 SCK = ~SCK;

  // Reference model state, one slot per instance.
  int         depth  [NI] = '{256, 256, 16};
  bit         auto_m [NI] = '{1'b0, 1'b1, 1'b1};
  logic [7:0] mem_m  [NI][256];
  bit         known  [NI][256];
  int         wa     [NI];
  int         ra     [NI];
  bit         wv     [NI];
  bit         rv     [NI];
  logic [7:0] dout_m [NI];
  bit         dout_k [NI];
  bit         tx_m   [NI];
  bit         err_m  [NI];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [7:0] dout_of(int i);
    case (i)
      0:       return d0;
      1:       return d1;
      default: return d2;
    endcase
  endfunction

  function automatic logic tx_of(int i);
    case (i)
      0:       return t0;
      1:       return t1;
      default: return t2;
    endcase
  endfunction

  function automatic logic err_of(int i);
    case (i)
      0:       return e0;
      1:       return e1;
      default: return e2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      wa[i] = 0;
      ra[i] = 0;
      wv[i] = 1'b0;
      rv[i] = 1'b0;
      dout_m[i] = 8'h00;
      dout_k[i] = 1'b1;
      tx_m[i] = 1'b0;
      err_m[i] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [9:0] w, input bit v);
    int p;
    p = int'(w[7:0]);
    for (int i = 0; i < NI; i++) begin
      tx_m[i]  = 1'b0;
      err_m[i] = 1'b0;
      if (v) begin
        case (w[9:8])
          2'd0: begin
            wa[i] = p % depth[i];
            wv[i] = 1'b1;
          end
          2'd1: begin
            if (wv[i]) begin
              mem_m[i][wa[i]] = w[7:0];
              known[i][wa[i]] = 1'b1;
              if (auto_m[i]) wa[i] = (wa[i] + 1) % depth[i];
            end else begin
              err_m[i] = 1'b1;
            end
          end
          2'd2: begin
            ra[i] = p % depth[i];
            rv[i] = 1'b1;
          end
          default: begin
            if (rv[i]) begin
              dout_m[i] = mem_m[i][ra[i]];
              dout_k[i] = known[i][ra[i]];
              tx_m[i] = 1'b1;
              if (auto_m[i]) ra[i] = (ra[i] + 1) % depth[i];
            end else begin
              err_m[i] = 1'b1;
            end
          end
        endcase
      end
    end
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s.u%0d.tx_valid", tag, i), 32'(tx_of(i)), 32'(tx_m[i]));
      check($sformatf("%s.u%0d.err", tag, i), 32'(err_of(i)), 32'(err_m[i]));
      // A read of a never-written byte gives an unknown value, so skip dout then.
      if (dout_k[i]) check($sformatf("%s.u%0d.dout", tag, i), 32'(dout_of(i)), 32'(dout_m[i]));
    end
  endtask

  // Drive one word on the falling edge and sample 1 ns after the rising edge.
  task automatic step(input logic [9:0] w, input bit v, input string tag);
    @(negedge SCK);
    din      = w;
    rx_valid = v;
    @(posedge SCK);
    #1;
    model_step(w, v);
    compare_all(tag);
  endtask

  initial begin
    logic [9:0] w;
    logic [7:0] p;
    bit         v;

    for (int i = 0; i < NI; i++)
      for (int a = 0; a < 256; a++) known[i][a] = 1'b0;
    rst = 1'b1;
    din = '0;
    rx_valid = 1'b0;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge SCK);
    rst = 1'b0;

    // Data commands issued before any pointer is loaded.
    step(10'h300, 1'b1, "rd_before_addr");
    step(10'h155, 1'b1, "wr_before_addr");
    step(10'h300, 1'b1, "rd_before_addr2");
    check("oo_dout_zero", 32'(d0), 32'h00);

    // Basic write then read.
    step(10'h0A5, 1'b1, "wr_addr");
    step(10'h13C, 1'b1, "wr_data");
    step(10'h2A5, 1'b1, "rd_addr");
    step(10'h300, 1'b1, "rd_data");
    check("wr_rd_dout", 32'(d0), 32'h3C);
    check("wr_rd_tx", 32'(t0), 32'h1);

    // Reset asserted mid-cycle while a tx_valid pulse is high.
    step(10'h300, 1'b1, "pre_reset_rd");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("midrst.u%0d.dout", i), 32'(dout_of(i)), 32'h00);
      check($sformatf("midrst.u%0d.tx", i), 32'(tx_of(i)), 32'h0);
      check($sformatf("midrst.u%0d.err", i), 32'(err_of(i)), 32'h0);
    end
    @(negedge SCK);
    rst = 1'b0;
    step(10'h300, 1'b1, "rd_after_reset");
    check("rd_after_reset_err", 32'(e0), 32'h1);

    // Auto-increment wrap from the top address back to 0.
    step(10'h0FF, 1'b1, "wrap_wa");
    step(10'h111, 1'b1, "wrap_wd1");
    step(10'h122, 1'b1, "wrap_wd2");
    step(10'h2FF, 1'b1, "wrap_ra");
    step(10'h300, 1'b1, "wrap_rd1");
    check("wrap_rd1_u1", 32'(d1), 32'h11);
    step(10'h300, 1'b1, "wrap_rd2");
    check("wrap_rd2_u1", 32'(d1), 32'h22);
    step(10'h200, 1'b1, "wrap_ra0");
    step(10'h300, 1'b1, "wrap_rd0");
    check("wrap_mem0_u1", 32'(d1), 32'h22);

    // Back-to-back words with no idle cycles between them.
    step(10'h010, 1'b1, "b2b0");
    step(10'h1EE, 1'b1, "b2b1");
    step(10'h210, 1'b1, "b2b2");
    step(10'h300, 1'b1, "b2b3");
    check("b2b_dout", 32'(d0), 32'hEE);
    step(10'h000, 1'b0, "b2b_idle");

    // rx_valid held low: din changes must have no effect.
    for (int k = 0; k < 20; k++) step(10'($urandom), 1'b0, "idle");
    step(10'h300, 1'b1, "idle_readback");

    // Random traffic. Addresses are drawn from a narrow band at each end of
    // the range so reads hit written bytes and pointers wrap often.
    for (int k = 0; k < 400; k++) begin
      v = ($urandom_range(0, 3) != 0);
      p = 8'($urandom);
      if ($urandom_range(0, 1) == 0) p = 8'($urandom_range(0, 7)) | 8'h00;
      else p = 8'($urandom_range(0, 7)) | 8'hF8;
      w = {2'($urandom_range(0, 3)), p};
      if (w[9:8] == 2'b01) w[7:0] = 8'($urandom);
      step(w, v, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Single-port RAM with command decoder, directly downstream of the SPI slave. Consumes the slave's 10-bit received word (rx_data/rx_valid) and returns read data to the slave on tx_data/tx_valid for serialisation on MISO. Bits [9:8] of each word select the command; bits [7:0] carry an address or write data. Holds separate write and read address pointers, with optional auto-increment and an error flag for out-of-order commands.

Parameters:
MEM_DEPTH, 256, number of 8-bit words; must equal 2**ADDR_SIZE.
ADDR_SIZE, 8, address width; legal range 1..8; address taken from din[ADDR_SIZE-1:0].
AUTO_INC, 0, when 1, the relevant pointer increments after each data write/read, wrapping MEM_DEPTH-1 -> 0.

Ports:
SCK  input  1  clock; all state updates on posedge.
rst  input  1  reset, asynchronous, active-high.
din  input  10  command word from SPI slave rx_data; [9:8] = cmd, [7:0] = payload.
rx_valid  input  1  din is valid this cycle; one-cycle pulse per word.
dout  output  8  read data to SPI slave tx_data.
tx_valid  output  1  one-cycle pulse; dout is valid.
err  output  1  one-cycle pulse on an illegal-order command.

Behaviour:
- Reset (async, while rst=1): dout=0, tx_valid=0, err=0, wr_addr=0, rd_addr=0, wr_addr_valid=0, rd_addr_valid=0. Memory contents are not cleared.
- Reset mid-operation: takes effect immediately; any pending tx_valid/err pulse is suppressed. The first command after reset deasserts is decoded normally.
- Decode happens only when rx_valid=1 at posedge SCK. When rx_valid=0, all state holds, tx_valid=0 and err=0.
- cmd 00 (write addr): wr_addr <= din[ADDR_SIZE-1:0]; wr_addr_valid <= 1.
- cmd 01 (write data):
  - If wr_addr_valid=1: mem[wr_addr] <= din[7:0]; if AUTO_INC, wr_addr <= wr_addr+1 (mod MEM_DEPTH).
  - Else: no write, err=1 for one cycle.
- cmd 10 (read addr): rd_addr <= din[ADDR_SIZE-1:0]; rd_addr_valid <= 1.
- cmd 11 (read data):
  - If rd_addr_valid=1: dout <= mem[rd_addr] and tx_valid=1 in the cycle after the posedge that sampled the command (registered, latency 1). If AUTO_INC, rd_addr <= rd_addr+1 (mod MEM_DEPTH).
  - Else: dout unchanged, tx_valid=0, err=1 for one cycle.
- tx_valid and err are exactly one cycle wide per triggering command. dout holds its last value until the next successful read.
- Address valid flags stay set until reset. A new address command simply overwrites the pointer.
- Single port: at most one memory access per cycle, guaranteed by one command per rx_valid.
- Read-after-write to the same address in consecutive words returns the newly written value, because the write completes at the posedge before the read is sampled.
- Payload bits above ADDR_SIZE are ignored for address commands.
- Wrap-around: with AUTO_INC=1, a pointer at MEM_DEPTH-1 returns to 0 after a data access.
- No handshake back-pressure: the upstream slave never issues a word faster than one per 10 SCK cycles. The block must nevertheless accept back-to-back rx_valid pulses correctly.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> dout=0x00, tx_valid=0 and err=0 immediately. A cmd 11 right after release -> err pulse, tx_valid stays 0.
- Write/read: din=0x0A5 (write addr 0xA5), din=0x13C (data 0x3C), din=0x2A5 (read addr 0xA5), din=0x300 -> tx_valid pulse one cycle later with dout=0x3C.
- Out of order: after reset, din=0x155 -> err pulse, no memory write. Then din=0x300 -> err pulse, dout stays 0x00.
- AUTO_INC=1 wrap: write addr 0xFF, then data 0x11 and data 0x22, then read addr 0xFF and two read-data commands -> dout 0x11 then 0x22. Confirm mem[0x00]=0x22.
- Back-to-back: rx_valid high on consecutive cycles with 0x010, 0x1EE, 0x210, 0x300 -> single tx_valid pulse, dout=0xEE. No err.
- rx_valid=0 with changing din for 20 cycles -> no state change, tx_valid=0 and err=0 throughout.
